// File: rtl/single_cycle_cpu.sv
// Single-cycle 32-bit MIPS subset core: every instruction fetches, executes and commits in one clk.
// Holds the program counter, register file, ALU, control decode, instruction ROM and data RAM.

module program_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_in,
    output logic [31:0] PC_out
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) PC_out <= '0;
        else       PC_out <= PC_in;
    end
endmodule

module register_file (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] memory [0:31];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) memory[i] <= '0;
        end else if (we && wa != 5'd0) begin
            memory[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : memory[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : memory[ra2];
endmodule

module single_cycle_cpu #(
    parameter int    IMEM_WORDS = 64,
    parameter int    DMEM_WORDS = 64,
    parameter string IMEM_FILE  = "instructions.mem"
) (
    input logic clk,
    input logic reset
);
    localparam int IA = $clog2(IMEM_WORDS);
    localparam int DA = $clog2(DMEM_WORDS);

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    logic [31:0] imem [0:IMEM_WORDS-1];
    logic [31:0] dmem [0:DMEM_WORDS-1];

    // Unloaded ROM words read as 0 (sll $0 = NOP), so fetch simply walks on.
    initial begin
        for (int i = 0; i < IMEM_WORDS; i++) imem[i] = '0;
    end

    logic [31:0] pc_cur, pc_next, pc_plus4, branch_target, instr;
    logic [31:0] imm_ext, alu_a, alu_b, alu_y, rd1, rd2, ram_rdata, wb_data;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, wb_addr;
    logic        zero;
    logic        reg_write, reg_dst_rd, alu_src_imm, imm_zext;
    logic        mem_write, mem_to_reg, branch_eq, branch_ne, jump;
    alu_op_t     alu_op;

    program_counter pc (
        .clk    (clk),
        .reset  (reset),
        .PC_in  (pc_next),
        .PC_out (pc_cur)
    );

    assign instr  = imem[pc_cur[IA+1:2]];
    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];

    always_comb begin
        reg_write   = 1'b0;
        reg_dst_rd  = 1'b0;
        alu_src_imm = 1'b0;
        imm_zext    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        branch_eq   = 1'b0;
        branch_ne   = 1'b0;
        jump        = 1'b0;
        alu_op      = ALU_ADD;
        case (opcode)
            6'h00: begin
                reg_dst_rd = 1'b1;
                case (funct)
                    6'h20: begin reg_write = 1'b1; alu_op = ALU_ADD; end
                    6'h22: begin reg_write = 1'b1; alu_op = ALU_SUB; end
                    6'h24: begin reg_write = 1'b1; alu_op = ALU_AND; end
                    6'h25: begin reg_write = 1'b1; alu_op = ALU_OR;  end
                    6'h2A: begin reg_write = 1'b1; alu_op = ALU_SLT; end
                    default: ;
                endcase
            end
            6'h23: begin reg_write = 1'b1; alu_src_imm = 1'b1; mem_to_reg = 1'b1; end
            6'h2B: begin alu_src_imm = 1'b1; mem_write = 1'b1; end
            6'h04: begin alu_op = ALU_SUB; branch_eq = 1'b1; end
            6'h05: begin alu_op = ALU_SUB; branch_ne = 1'b1; end
            6'h08: begin reg_write = 1'b1; alu_src_imm = 1'b1; end
            6'h0C: begin reg_write = 1'b1; alu_src_imm = 1'b1; imm_zext = 1'b1; alu_op = ALU_AND; end
            6'h02: jump = 1'b1;
            default: ;
        endcase
    end

    register_file Reg_file (
        .clk   (clk),
        .reset (reset),
        .we    (reg_write),
        .ra1   (rs),
        .ra2   (rt),
        .wa    (wb_addr),
        .wd    (wb_data),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    assign imm_ext = imm_zext ? {16'h0000, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    assign alu_a   = rd1;
    assign alu_b   = alu_src_imm ? imm_ext : rd2;

    always_comb begin
        alu_y = '0;
        case (alu_op)
            ALU_ADD: alu_y = alu_a + alu_b;
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_y = '0;
        endcase
    end

    assign zero = (alu_y == 32'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
        end else if (mem_write) begin
            dmem[alu_y[DA+1:2]] <= rd2;
        end
    end

    assign ram_rdata = dmem[alu_y[DA+1:2]];
    assign wb_data   = mem_to_reg ? ram_rdata : alu_y;
    assign wb_addr   = reg_dst_rd ? rd : rt;

    assign pc_plus4      = pc_cur + 32'd4;
    assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};

    always_comb begin
        pc_next = pc_plus4;
        if (jump)
            pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if ((branch_eq && zero) || (branch_ne && !zero))
            pc_next = branch_target;
    end
endmodule

// File: tb/tb_single_cycle_cpu.sv
// Bench for single_cycle_cpu: a directed lab program plus random programs, each cycle compared
// against an instruction-level reference simulator; reset is checked at start, per program and mid-run.

module tb_single_cycle_cpu;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    single_cycle_cpu #(
        .IMEM_WORDS (64),
        .DMEM_WORDS (64),
        .IMEM_FILE  ("")
    ) dut (
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rom   [64];
    logic [31:0] m_reg [32];
    logic [31:0] m_ram [64];
    logic [31:0] m_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(int funct, int rd, int rs, int rt);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, funct[5:0]};
    endfunction

    function automatic logic [31:0] i_ins(int op, int rt, int rs, int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] j_ins(int target);
        return {6'h02, target[25:0]};
    endfunction

    task automatic model_reset();
        m_pc = '0;
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        for (int i = 0; i < 64; i++) m_ram[i] = '0;
    endtask

    task automatic m_write(input logic [4:0] idx, input logic [31:0] val);
        if (idx != 5'd0) m_reg[idx] = val;
    endtask

    // Instruction-set reference: one call retires one instruction.
    task automatic model_step();
        logic [31:0] ins, a, b, se, ze, addr, npc;
        int widx, ridx;
        widx = int'((m_pc / 4) % 64);
        ins  = rom[widx];
        a    = m_reg[ins[25:21]];
        b    = m_reg[ins[20:16]];
        se   = {{16{ins[15]}}, ins[15:0]};
        ze   = {16'h0000, ins[15:0]};
        addr = a + se;
        ridx = int'((addr / 4) % 64);
        npc  = m_pc + 4;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20: m_write(ins[15:11], a + b);
                6'h22: m_write(ins[15:11], a - b);
                6'h24: m_write(ins[15:11], a & b);
                6'h25: m_write(ins[15:11], a | b);
                6'h2A: m_write(ins[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                default: ;
            endcase
            6'h23: m_write(ins[20:16], m_ram[ridx]);
            6'h2B: m_ram[ridx] = b;
            6'h04: if (a == b) npc = m_pc + 4 + (se << 2);
            6'h05: if (a != b) npc = m_pc + 4 + (se << 2);
            6'h08: m_write(ins[20:16], a + se);
            6'h0C: m_write(ins[20:16], a & ze);
            6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
            default: ;
        endcase
        m_pc = npc;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("pc", dut.pc.PC_out, m_pc);
        for (int i = 0; i < 32; i++)
            check($sformatf("reg%0d", i), dut.Reg_file.memory[i], m_reg[i]);
    endtask

    task automatic compare_ram();
        for (int i = 0; i < 64; i++)
            check($sformatf("ram%0d", i), dut.dmem[i], m_ram[i]);
    endtask

    task automatic check_cleared();
        check("rst_pc", dut.pc.PC_out, 32'h0);
        for (int i = 0; i < 32; i++)
            check($sformatf("rst_reg%0d", i), dut.Reg_file.memory[i], 32'h0);
        for (int i = 0; i < 64; i++)
            check($sformatf("rst_ram%0d", i), dut.dmem[i], 32'h0);
    endtask

    task automatic load_rom();
        for (int i = 0; i < 64; i++) dut.imem[i] = rom[i];
    endtask

    task automatic apply_reset(input bit reload);
        @(negedge clk);
        reset = 1'b1;
        if (reload) load_rom();
        #1;
        check_cleared();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_ins();
        int k, rs, rt, rd;
        k  = int'($urandom_range(0, 13));
        rs = int'($urandom_range(0, 7));
        rt = int'($urandom_range(0, 7));
        rd = int'($urandom_range(0, 7));
        case (k)
            0:  return r_ins(32'h20, rd, rs, rt);
            1:  return r_ins(32'h22, rd, rs, rt);
            2:  return r_ins(32'h24, rd, rs, rt);
            3:  return r_ins(32'h25, rd, rs, rt);
            4:  return r_ins(32'h2A, rd, rs, rt);
            5:  return i_ins(32'h08, rt, rs, int'($urandom_range(0, 65535)));
            6:  return i_ins(32'h0C, rt, rs, int'($urandom_range(0, 65535)));
            7:  return i_ins(32'h23, rt, rs, int'($urandom_range(0, 65535)));
            8:  return i_ins(32'h2B, rt, rs, int'($urandom_range(0, 65535)));
            9:  return i_ins(32'h04, rt, rs, int'($urandom_range(0, 6)) - 3);
            10: return i_ins(32'h05, rt, rs, int'($urandom_range(0, 6)) - 3);
            11: return j_ins(int'($urandom_range(0, 63)));
            12: return {6'h30 + 6'($urandom_range(0, 15)), 26'($urandom)};
            default: return r_ins(int'($urandom_range(0, 31)), rd, rs, rt);
        endcase
    endfunction

    initial begin
        #1;
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
        rom[0]  = i_ins(32'h08, 16, 0, 5);          // addi $s0,$0,5
        rom[1]  = i_ins(32'h08, 17, 0, -3);         // addi $s1,$0,-3
        rom[2]  = r_ins(32'h20, 8, 16, 17);         // add  $t0,$s0,$s1
        rom[3]  = r_ins(32'h22, 9, 16, 17);         // sub  $t1,$s0,$s1
        rom[4]  = r_ins(32'h2A, 10, 17, 16);        // slt  $t2,$s1,$s0
        rom[5]  = i_ins(32'h08, 18, 0, 32'h0F0F);   // addi $s2,$0,0x0F0F
        rom[6]  = i_ins(32'h0C, 11, 18, 32'h00FF);  // andi $t3,$s2,0x00FF
        rom[7]  = r_ins(32'h25, 12, 18, 16);        // or   $t4,$s2,$s0
        rom[8]  = i_ins(32'h23, 15, 0, 8);          // lw   $t7,8($0)
        rom[9]  = i_ins(32'h2B, 16, 0, 4);          // sw   $s0,4($0)
        rom[10] = i_ins(32'h23, 13, 0, 4);          // lw   $t5,4($0)
        rom[11] = i_ins(32'h04, 16, 16, 2);         // beq  $s0,$s0,+2
        rom[12] = i_ins(32'h08, 24, 0, 1);
        rom[13] = i_ins(32'h08, 24, 0, 2);
        rom[14] = j_ins(32'h10);                    // j    0x10
        rom[15] = i_ins(32'h08, 24, 0, 3);
        rom[16] = i_ins(32'h05, 16, 16, 5);         // bne  $s0,$s0 (not taken)
        rom[17] = i_ins(32'h08, 0, 0, 7);           // addi $0,$0,7
        rom[18] = r_ins(32'h20, 14, 0, 0);          // add  $t6,$0,$0
        load_rom();

        repeat (3) @(posedge clk);
        #1;
        check_cleared();
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        step(); check("pc_after_rst1", dut.pc.PC_out, 32'h4);
        step(); check("pc_after_rst2", dut.pc.PC_out, 32'h8);
        step(); check("pc_after_rst3", dut.pc.PC_out, 32'hC);
        repeat (8) step();
        step(); check("beq_taken_pc", dut.pc.PC_out, 32'd56);
        step(); check("j_pc", dut.pc.PC_out, 32'h40);
        step(); check("bne_not_taken_pc", dut.pc.PC_out, 32'h44);
        step();
        step();
        check("add_t0",  dut.Reg_file.memory[8],  32'h2);
        check("sub_t1",  dut.Reg_file.memory[9],  32'h8);
        check("slt_t2",  dut.Reg_file.memory[10], 32'h1);
        check("andi_t3", dut.Reg_file.memory[11], 32'h0000000F);
        check("or_t4",   dut.Reg_file.memory[12], 32'h00000F0F);
        check("lw_t5",   dut.Reg_file.memory[13], 32'h5);
        check("add_t6",  dut.Reg_file.memory[14], 32'h0);
        check("lw8_t7",  dut.Reg_file.memory[15], 32'h0);
        check("skip_t8", dut.Reg_file.memory[24], 32'h0);
        check("zero_r0", dut.Reg_file.memory[0],  32'h0);
        check("sw_ram1", dut.dmem[1],             32'h5);
        repeat (4) step();
        compare_ram();

        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 64; i++) rom[i] = (i < 48) ? rand_ins() : 32'h0;
            apply_reset(1'b1);
            for (int c = 0; c < 150; c++) begin
                step();
                if (p == 2 && c == 70) apply_reset(1'b0);
            end
            compare_ram();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
